fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 45 ++++
 rtl/fetch_unit.sv | 158 +++++++++++++++
 tb/tb_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its surroundings (instruction memory, decode).
// The fetch unit takes the slave side; the memory/decode environment takes the master side.
interface fetch_unit_if;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] branch_pc_plus1;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;

    logic [31:0] pc_out;
    logic [5:0]  if_op;
    logic [4:0]  if_rs;
    logic [4:0]  if_rt;
    logic [15:0] if_imm;

    logic        id_valid;
    logic [5:0]  id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [15:0] id_imm;
    logic [31:0] id_pc_plus1;
    logic        halted;
    logic [31:0] fetch_count;

    modport master (
        output stall, flush, branch_taken, branch_offset, branch_pc_plus1,
               jump, jump_target, jr, jr_target,
               if_op, if_rs, if_rt, if_imm,
        input  pc_out, id_valid, id_op, id_rs, id_rt, id_rd, id_imm, id_pc_plus1,
               halted, fetch_count
    );

    modport slave (
        input  stall, flush, branch_taken, branch_offset, branch_pc_plus1,
               jump, jump_target, jr, jr_target,
               if_op, if_rs, if_rt, if_imm,
        output pc_out, id_valid, id_op, id_rs, id_rt, id_rd, id_imm, id_pc_plus1,
               halted, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, redirect selection, IF/ID pipeline register and a
// HALT state that freezes fetch until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [5:0]  HALT_OP  = 6'h3F
) (
    input logic         clk,
    input logic         rst_n,
    fetch_unit_if.slave io_bus
);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    state_e      r_state;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [5:0]  r_id_op;
    logic [4:0]  r_id_rs;
    logic [4:0]  r_id_rt;
    logic [4:0]  r_id_rd;
    logic [15:0] r_id_imm;
    logic [31:0] r_id_pc_plus1;
    logic [31:0] r_fetch_count;

    state_e      w_state_next;
    logic [31:0] w_pc_next;
    logic        w_id_valid_next;
    logic [5:0]  w_id_op_next;
    logic [4:0]  w_id_rs_next;
    logic [4:0]  w_id_rt_next;
    logic [4:0]  w_id_rd_next;
    logic [15:0] w_id_imm_next;
    logic [31:0] w_id_pc_plus1_next;
    logic [31:0] w_fetch_count_next;

    logic [31:0] w_pc_plus1;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;
    logic        w_redirect;
    logic        w_halt_detect;
    logic        w_bubble;
    logic        w_load;

    assign w_pc_plus1      = r_pc + 32'd1;
    assign w_branch_target = io_bus.branch_pc_plus1
                           + {{16{io_bus.branch_offset[15]}}, io_bus.branch_offset};
    assign w_jump_target   = {io_bus.branch_pc_plus1[31:26], io_bus.jump_target};
    assign w_redirect      = io_bus.jr | io_bus.jump | io_bus.branch_taken;

    // A HALT opcode only counts when it is on the committed path and not being held back.
    assign w_halt_detect = (io_bus.if_op == HALT_OP) & ~w_redirect & ~io_bus.flush
                         & ~io_bus.stall;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_bubble     = 1'b0;
        w_load       = 1'b0;

        unique case (r_state)
            StRun: begin
                if (io_bus.jr) begin
                    w_pc_next = io_bus.jr_target;
                end else if (io_bus.jump) begin
                    w_pc_next = w_jump_target;
                end else if (io_bus.branch_taken) begin
                    w_pc_next = w_branch_target;
                end else if (io_bus.stall || w_halt_detect) begin
                    w_pc_next = r_pc;
                end else begin
                    w_pc_next = w_pc_plus1;
                end

                w_bubble = w_redirect | io_bus.flush;
                w_load   = ~w_bubble & ~io_bus.stall;

                if (w_halt_detect) begin
                    w_state_next = StHalt;
                end
            end
            StHalt: begin
                // Redirects are ignored here; only stall can keep IF/ID from draining.
                w_bubble = io_bus.flush | ~io_bus.stall;
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    always_comb begin
        w_id_valid_next    = r_id_valid;
        w_id_op_next       = r_id_op;
        w_id_rs_next       = r_id_rs;
        w_id_rt_next       = r_id_rt;
        w_id_rd_next       = r_id_rd;
        w_id_imm_next      = r_id_imm;
        w_id_pc_plus1_next = r_id_pc_plus1;
        w_fetch_count_next = r_fetch_count;

        if (w_bubble) begin
            w_id_valid_next    = 1'b0;
            w_id_op_next       = 6'd0;
            w_id_rs_next       = 5'd0;
            w_id_rt_next       = 5'd0;
            w_id_rd_next       = 5'd0;
            w_id_imm_next      = 16'd0;
            w_id_pc_plus1_next = 32'd0;
        end else if (w_load) begin
            w_id_valid_next    = 1'b1;
            w_id_op_next       = io_bus.if_op;
            w_id_rs_next       = io_bus.if_rs;
            w_id_rt_next       = io_bus.if_rt;
            w_id_rd_next       = io_bus.if_imm[15:11];
            w_id_imm_next      = io_bus.if_imm;
            w_id_pc_plus1_next = w_pc_plus1;
            w_fetch_count_next = r_fetch_count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StRun;
            r_pc          <= RESET_PC;
            r_id_valid    <= 1'b0;
            r_id_op       <= 6'd0;
            r_id_rs       <= 5'd0;
            r_id_rt       <= 5'd0;
            r_id_rd       <= 5'd0;
            r_id_imm      <= 16'd0;
            r_id_pc_plus1 <= 32'd0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_id_valid    <= w_id_valid_next;
            r_id_op       <= w_id_op_next;
            r_id_rs       <= w_id_rs_next;
            r_id_rt       <= w_id_rt_next;
            r_id_rd       <= w_id_rd_next;
            r_id_imm      <= w_id_imm_next;
            r_id_pc_plus1 <= w_id_pc_plus1_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    assign io_bus.pc_out      = r_pc;
    assign io_bus.id_valid    = r_id_valid;
    assign io_bus.id_op       = r_id_op;
    assign io_bus.id_rs       = r_id_rs;
    assign io_bus.id_rt       = r_id_rt;
    assign io_bus.id_rd       = r_id_rd;
    assign io_bus.id_imm      = r_id_imm;
    assign io_bus.id_pc_plus1 = r_id_pc_plus1;
    assign io_bus.halted      = (r_state == StHalt);
    assign io_bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random control traffic, each cycle compared
// against a cycle-level model of PC, IF/ID contents, halt flag and fetch count.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [5:0]  HALT     = 6'h3F;

    logic clk;
    logic rst_n;
    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .HALT_OP  (HALT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.slave)
    );

    // 64-word instruction memory, addressed by the low PC bits.
    logic [31:0] mem [64];
    logic [31:0] mem_word;
    assign mem_word   = mem[bus.pc_out[5:0]];
    assign bus.if_op  = mem_word[31:26];
    assign bus.if_rs  = mem_word[25:21];
    assign bus.if_rt  = mem_word[20:16];
    assign bus.if_imm = mem_word[15:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    // Reference state
    logic [31:0] m_pc;
    logic        m_halted;
    logic        m_valid;
    logic [5:0]  m_op;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [15:0] m_imm;
    logic [31:0] m_pcp1;
    logic [31:0] m_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.stall           = 1'b0;
        bus.flush           = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.branch_offset   = 16'd0;
        bus.branch_pc_plus1 = 32'd0;
        bus.jump            = 1'b0;
        bus.jump_target     = 26'd0;
        bus.jr              = 1'b0;
        bus.jr_target       = 32'd0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0;
        m_op    = '0;
        m_rs    = '0;
        m_rt    = '0;
        m_rd    = '0;
        m_imm   = '0;
        m_pcp1  = '0;
    endtask

    task automatic model_reset();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        m_count  = 32'd0;
        model_bubble();
    endtask

    task automatic check_outputs();
        chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
        chk("id_op", 32'(bus.id_op), 32'(m_op));
        chk("id_rs", 32'(bus.id_rs), 32'(m_rs));
        chk("id_rt", 32'(bus.id_rt), 32'(m_rt));
        chk("id_rd", 32'(bus.id_rd), 32'(m_rd));
        chk("id_imm", 32'(bus.id_imm), 32'(m_imm));
        chk("id_pc_plus1", bus.id_pc_plus1, m_pcp1);
        chk("halted", 32'(bus.halted), 32'(m_halted));
        chk("fetch_count", bus.fetch_count, m_count);
    endtask

    // Called just after a rising edge with this cycle's inputs already driven.
    task automatic cycle();
        logic [31:0] word;
        logic [31:0] npc;
        logic        redir;
        #1;
        chk("pc_out", bus.pc_out, m_pc);
        word  = mem[m_pc[5:0]];
        redir = bus.jr | bus.jump | bus.branch_taken;
        if (m_halted) begin
            if (bus.flush || !bus.stall) model_bubble();
        end else begin
            if (bus.jr) npc = bus.jr_target;
            else if (bus.jump) npc = {bus.branch_pc_plus1[31:26], bus.jump_target};
            else if (bus.branch_taken) npc = bus.branch_pc_plus1 + 32'($signed(bus.branch_offset));
            else if (bus.stall) npc = m_pc;
            else if (word[31:26] == HALT && !bus.flush) npc = m_pc;
            else npc = m_pc + 32'd1;

            if (redir || bus.flush) begin
                model_bubble();
            end else if (!bus.stall) begin
                m_valid = 1'b1;
                m_op    = word[31:26];
                m_rs    = word[25:21];
                m_rt    = word[20:16];
                m_rd    = word[15:11];
                m_imm   = word[15:0];
                m_pcp1  = m_pc + 32'd1;
                m_count = m_count + 32'd1;
                if (word[31:26] == HALT) m_halted = 1'b1;
            end
            m_pc = npc;
        end
        @(posedge clk);
        #1;
        check_outputs();
        clear_inputs();
    endtask

    // Asynchronous reset asserted mid-cycle, released just after the following edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc_out", bus.pc_out, RESET_PC);
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i] = {6'($urandom_range(0, 62)), 26'($urandom())};
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        fill_mem();
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Sequential fetch 0..4, then a two-cycle stall at PC=5
        for (int i = 0; i < 5; i++) cycle();
        chk("count_after_5", bus.fetch_count, 32'd5);
        bus.stall = 1'b1;
        cycle();
        bus.stall = 1'b1;
        cycle();
        cycle();

        // Taken branch with simultaneous stall: 10 + (-4) = 6
        bus.branch_taken    = 1'b1;
        bus.branch_pc_plus1 = 32'd10;
        bus.branch_offset   = 16'hFFFC;
        bus.stall           = 1'b1;
        cycle();
        chk("branch_pc", bus.pc_out, 32'd6);

        // jr beats jump
        bus.jr          = 1'b1;
        bus.jr_target   = 32'h40;
        bus.jump        = 1'b1;
        bus.jump_target = 26'h123;
        cycle();
        chk("jr_pc", bus.pc_out, 32'h40);

        bus.jump            = 1'b1;
        bus.branch_pc_plus1 = 32'hF000_0001;
        bus.jump_target     = 26'h10;
        cycle();
        chk("jump_pc", bus.pc_out, 32'hF000_0010);
        cycle();

        // Flush alone, then PC wrap at the top of the address space
        bus.flush = 1'b1;
        cycle();
        bus.jr        = 1'b1;
        bus.jr_target = 32'hFFFF_FFFF;
        cycle();
        cycle();
        chk("wrap_pc", bus.pc_out, 32'd0);

        // HALT opcode at PC=7 killed by a taken branch
        mem[7] = {HALT, 26'h0ABCDEF};
        bus.jr        = 1'b1;
        bus.jr_target = 32'd7;
        cycle();
        bus.branch_taken    = 1'b1;
        bus.branch_pc_plus1 = 32'd10;
        bus.branch_offset   = 16'hFFFC;
        cycle();
        chk("no_halt", 32'(bus.halted), 32'd0);

        // HALT opcode at PC=7 taken for real
        bus.jr        = 1'b1;
        bus.jr_target = 32'd7;
        cycle();
        bus.stall = 1'b1;
        cycle();
        cycle();
        chk("halt_flag", 32'(bus.halted), 32'd1);
        chk("halt_op", 32'(bus.id_op), 32'(HALT));
        cycle();
        bus.jump        = 1'b1;
        bus.jump_target = 26'h20;
        cycle();
        bus.stall = 1'b1;
        cycle();
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        cycle();
        chk("halt_pc_held", bus.pc_out, 32'd7);
        do_reset();
        chk("halt_cleared", 32'(bus.halted), 32'd0);

        // Random control traffic, memory free of HALT opcodes
        fill_mem();
        for (int n = 0; n < 300; n++) begin
            bus.stall           = ($urandom_range(0, 99) < 25);
            bus.flush           = ($urandom_range(0, 99) < 10);
            bus.branch_taken    = ($urandom_range(0, 99) < 10);
            bus.branch_offset   = 16'($urandom());
            bus.branch_pc_plus1 = $urandom();
            bus.jump            = ($urandom_range(0, 99) < 5);
            bus.jump_target     = 26'($urandom());
            bus.jr              = ($urandom_range(0, 99) < 5);
            bus.jr_target       = $urandom();
            cycle();
        end

        // Reset in the middle of live traffic
        do_reset();
        for (int i = 0; i < 4; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
